// File: rtl/isa_target_pkg.sv
// Shared register offsets, STATUS/CONTROL bit positions and read-FSM states
// for the XT I/O-channel target.
package isa_target_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_RX_OVF       = 2;
    localparam int ST_IRQ_PEND     = 3;
    localparam int ST_TC_FLAG      = 4;
    localparam int ST_DMA_BUSY     = 7;

    localparam int CTL_IRQ_EN = 0;
    localparam int CTL_DMA_EN = 1;
    localparam int CTL_FLUSH  = 2;

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE} rd_state_e;

endpackage

// File: rtl/isa_target_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally so the bus side
// can latch it before popping.
module isa_target_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    // Flush has priority over both push and pop in the same clock.
    assign push_ok = push_i & ~full_o  & ~flush_i;
    assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/isa_io_target.sv
// XT expansion-bus I/O target: 4-port window, RX/TX FIFOs, wait states, IRQ/DRQ.
// Define ISA_TARGET_TC_IRQ_EN to latch DMA terminal count into tc_flag and stop DMA.
module isa_io_target
    import isa_target_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR   = 10'h300,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic        address_enable_n,
    input  logic [7:0]  data_bus_in,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_en,
    input  logic        io_read_n,
    input  logic        io_write_n,
    output logic        io_channel_ready,
    output logic        interrupt_request,
    output logic        dma_request,
    input  logic        dma_acknowledge_n,
    input  logic        terminal_count_n,
    input  logic [7:0]  dev_rx_data,
    input  logic        dev_rx_valid,
    output logic        dev_rx_ready,
    output logic [7:0]  dev_tx_data,
    output logic        dev_tx_valid,
    input  logic        dev_tx_ready
);
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    rd_state_e   state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_pop_q, rd_pop_d;
    logic        rd_held_q, wr_held_q, dack_held_q;
    logic        irq_en_q, dma_en_q, flush_q, rx_ovf_q, dma_busy_q, irq_q, drq_q;
    logic        tc_flag, tc_set;
    logic        sel, dma_sel, hit, rd_go, wr_go, dack_fall, busy_tail;
    logic [1:0]  offset;
    logic [7:0]  status_val, control_val, reg_rdata, rx_head;
    logic        rx_full, rx_empty, rx_pop, tx_full, tx_empty, tx_push;
    logic [CW-1:0] rx_count, tx_count;
    logic        unused_ok;

    isa_target_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clock), .rst_n_i(reset_n),
        .push_i(dev_rx_valid), .push_data_i(dev_rx_data),
        .pop_i(rx_pop), .flush_i(flush_q),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    isa_target_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clock), .rst_n_i(reset_n),
        .push_i(tx_push), .push_data_i(data_bus_in),
        .pop_i(dev_tx_valid & dev_tx_ready), .flush_i(flush_q),
        .head_o(dev_tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    assign unused_ok = ^{rx_count, tx_count};

    // "held" flags reset to 1 so a strobe still asserted after reset is not an edge.
    assign rd_go     = ~rd_held_q & ~io_read_n & hit;
    assign wr_go     = ~wr_held_q & ~io_write_n & hit;
    assign dack_fall = ~dack_held_q & ~dma_acknowledge_n;
    assign sel       = ~address_enable_n & (address[9:2] == BASE_ADDR[9:2]) & (address[19:10] == 10'd0);
    assign dma_sel   = ~dma_acknowledge_n;
    assign hit       = sel | dma_sel;
    assign offset    = dma_sel ? REG_DATA : address[1:0];
    assign tx_push   = wr_go & (offset == REG_DATA);
    assign busy_tail = dma_busy_q | (rd_go & dma_sel);

`ifdef ISA_TARGET_TC_IRQ_EN
    logic tc_flag_q;
    assign tc_set = rd_go & dma_sel & ~terminal_count_n;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                              tc_flag_q <= 1'b0;
        else if (tc_set)                                           tc_flag_q <= 1'b1;
        else if (wr_go && offset == REG_STATUS && data_bus_in[4])  tc_flag_q <= 1'b0;
    end
    assign tc_flag = tc_flag_q;
`else
    logic unused_tc;
    assign unused_tc = terminal_count_n;
    assign tc_set    = 1'b0;
    assign tc_flag   = 1'b0;
`endif

    always_comb begin
        status_val                  = '0;
        status_val[ST_RX_NOT_EMPTY] = ~rx_empty;
        status_val[ST_TX_NOT_FULL]  = ~tx_full;
        status_val[ST_RX_OVF]       = rx_ovf_q;
        status_val[ST_IRQ_PEND]     = irq_q;
        status_val[ST_TC_FLAG]      = tc_flag;
        status_val[ST_DMA_BUSY]     = dma_busy_q;
        control_val                 = '0;
        control_val[CTL_IRQ_EN]     = irq_en_q;
        control_val[CTL_DMA_EN]     = dma_en_q;
        control_val[CTL_FLUSH]      = flush_q;
        case (offset)
            REG_DATA:    reg_rdata = rx_empty ? 8'h00 : rx_head;
            REG_STATUS:  reg_rdata = status_val;
            REG_CONTROL: reg_rdata = control_val;
            default:     reg_rdata = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_data_d  = rd_data_q;
        rd_pop_d   = rd_pop_q;
        rx_pop     = 1'b0;
        case (state_q)
            IDLE: if (rd_go) begin
                rd_data_d  = reg_rdata;
                wait_cnt_d = '0;
                if (offset == REG_DATA && rx_empty) begin
                    rd_pop_d = 1'b0;
                    state_d  = DRIVE;
                end else if (WAIT_STATES == 0) begin
                    rx_pop   = (offset == REG_DATA);
                    rd_pop_d = 1'b0;
                    state_d  = DRIVE;
                end else begin
                    rd_pop_d = (offset == REG_DATA);
                    state_d  = WAIT;
                end
            end
            WAIT: if (wait_cnt_q == WAIT_LAST) begin
                rx_pop   = rd_pop_q;
                rd_pop_d = 1'b0;
                state_d  = DRIVE;
            end else begin
                wait_cnt_d = wait_cnt_q + 3'd1;
            end
            DRIVE: if (io_read_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            rd_data_q   <= '0;
            rd_pop_q    <= 1'b0;
            rd_held_q   <= 1'b1;
            wr_held_q   <= 1'b1;
            dack_held_q <= 1'b1;
            irq_en_q    <= 1'b0;
            dma_en_q    <= 1'b0;
            flush_q     <= 1'b0;
            rx_ovf_q    <= 1'b0;
            dma_busy_q  <= 1'b0;
            irq_q       <= 1'b0;
            drq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_pop_q    <= rd_pop_d;
            rd_held_q   <= ~io_read_n;
            wr_held_q   <= ~io_write_n;
            dack_held_q <= ~dma_acknowledge_n;
            if (wr_go && offset == REG_CONTROL) begin
                irq_en_q <= data_bus_in[CTL_IRQ_EN];
                dma_en_q <= data_bus_in[CTL_DMA_EN];
                flush_q  <= data_bus_in[CTL_FLUSH];
            end else begin
                flush_q  <= 1'b0;
            end
            if (tc_set) dma_en_q <= 1'b0;
            if (dev_rx_valid && rx_full)                                rx_ovf_q <= 1'b1;
            else if (wr_go && offset == REG_STATUS && data_bus_in[2])   rx_ovf_q <= 1'b0;
            if (dma_acknowledge_n) dma_busy_q <= 1'b0;
            else if (dack_fall)    dma_busy_q <= 1'b1;
            irq_q <= irq_en_q & (~rx_empty | rx_ovf_q | tc_flag);
            drq_q <= dma_en_q & ~rx_empty & ~busy_tail;
        end
    end

    assign io_channel_ready  = (state_q != WAIT);
    assign data_bus_out_en   = (state_q == DRIVE);
    assign data_bus_out      = data_bus_out_en ? rd_data_q : 8'h00;
    assign interrupt_request = irq_q;
    assign dma_request       = drq_q;
    assign dev_rx_ready      = ~rx_full;
    assign dev_tx_valid      = ~tx_empty;

endmodule

// File: tb/tb_isa_io_target.sv
// Directed bench for isa_io_target: register table, FIFO paths, DMA/TC and reset corners.
module tb_isa_io_target;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [19:0] address;
    logic        address_enable_n;
    logic [7:0]  data_bus_in;
    logic [7:0]  data_bus_out;
    logic        data_bus_out_en;
    logic        io_read_n, io_write_n, io_channel_ready;
    logic        interrupt_request, dma_request, dma_acknowledge_n, terminal_count_n;
    logic [7:0]  dev_rx_data, dev_tx_data;
    logic        dev_rx_valid, dev_rx_ready, dev_tx_valid, dev_tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    isa_io_target #(.BASE_ADDR(10'h300), .FIFO_DEPTH(16), .WAIT_STATES(2)) dut (
        .clock(clock), .reset_n(reset_n), .address(address),
        .address_enable_n(address_enable_n), .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out), .data_bus_out_en(data_bus_out_en),
        .io_read_n(io_read_n), .io_write_n(io_write_n), .io_channel_ready(io_channel_ready),
        .interrupt_request(interrupt_request), .dma_request(dma_request),
        .dma_acknowledge_n(dma_acknowledge_n), .terminal_count_n(terminal_count_n),
        .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
        .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready)
    );

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic        exp_hit;
        logic [7:0]  exp_data;
        logic        chk_w;
        int          exp_w;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [19:0] addr, input logic [7:0] d);
        address = addr; address_enable_n = 1'b0; data_bus_in = d; io_write_n = 1'b0;
        @(negedge clock);
        io_write_n = 1'b1;
        @(negedge clock);
        $display("write addr=%05h data=%02h", addr, d);
    endtask

    task automatic do_read(input logic [19:0] addr, input logic aen,
                           output logic hit, output logic [7:0] data, output int waits);
        address = addr; address_enable_n = aen; io_read_n = 1'b0;
        hit = 1'b0; data = 8'h00; waits = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            @(negedge clock);
            if (data_bus_out_en) begin
                hit = 1'b1; data = data_bus_out;
            end else if (!io_channel_ready) begin
                waits++;
            end
        end
        if (hit) begin
            @(negedge clock);
            check("drive_hold_en", {31'd0, data_bus_out_en}, 32'd1);
            check("drive_hold_data", {24'd0, data_bus_out}, {24'd0, data});
        end
        io_read_n = 1'b1;
        @(negedge clock);
        if (hit) check("release_en", {31'd0, data_bus_out_en}, 32'd0);
        address_enable_n = 1'b0;
        $display("read addr=%05h aen=%0b hit=%0b data=%02h waits=%0d", addr, aen, hit, data, waits);
    endtask

    task automatic push_rx(input logic [7:0] d);
        dev_rx_data = d; dev_rx_valid = 1'b1;
        @(negedge clock);
        dev_rx_valid = 1'b0;
    endtask

    // Read helper that also checks the returned byte.
    task automatic read_expect(input string name, input logic [19:0] addr, input logic [7:0] exp);
        logic h; logic [7:0] d; int w;
        do_read(addr, 1'b0, h, d, w);
        check({name, "_hit"}, {31'd0, h}, 32'd1);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    initial begin
        logic        h;
        logic [7:0]  d;
        int          w;
        logic [19:0] ra;

        reset_n = 1'b0; address = '0; address_enable_n = 1'b0; data_bus_in = '0;
        io_read_n = 1'b1; io_write_n = 1'b1; dma_acknowledge_n = 1'b1; terminal_count_n = 1'b1;
        dev_rx_data = '0; dev_rx_valid = 1'b0; dev_tx_ready = 1'b0;

        #1;
        check("rst_ready", {31'd0, io_channel_ready}, 32'd1);
        check("rst_dout", {24'd0, data_bus_out}, 32'd0);
        check("rst_en", {31'd0, data_bus_out_en}, 32'd0);
        check("rst_irq", {31'd0, interrupt_request}, 32'd0);
        check("rst_drq", {31'd0, dma_request}, 32'd0);
        check("rst_txv", {31'd0, dev_tx_valid}, 32'd0);
        check("rst_rxr", {31'd0, dev_rx_ready}, 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        vt[0]  = '{20'h00301, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 0};
        vt[1]  = '{20'h00302, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0};
        vt[2]  = '{20'h00303, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 0};
        vt[3]  = '{20'h00303, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 0};
        vt[4]  = '{20'h00303, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 0};
        vt[5]  = '{20'h00302, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 0};
        vt[6]  = '{20'h00302, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 0};
        vt[7]  = '{20'h00302, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        vt[8]  = '{20'h00300, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 0};
        vt[9]  = '{20'h00304, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        vt[10] = '{20'h10300, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        vt[11] = '{20'h00306, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].wdata);
            end else begin
                do_read(vt[i].addr, 1'b0, h, d, w);
                check($sformatf("tbl%0d_hit", i), {31'd0, h}, {31'd0, vt[i].exp_hit});
                if (vt[i].exp_hit) check($sformatf("tbl%0d_data", i), {24'd0, d}, {24'd0, vt[i].exp_data});
                if (vt[i].chk_w) check($sformatf("tbl%0d_waits", i), w, vt[i].exp_w);
            end
        end
        check("unsel_write_no_tx", {31'd0, dev_tx_valid}, 32'd0);

        // TX path
        do_write(20'h00300, 8'hA5);
        check("tx_valid", {31'd0, dev_tx_valid}, 32'd1);
        check("tx_data", {24'd0, dev_tx_data}, 32'hA5);
        dev_tx_ready = 1'b1;
        @(negedge clock);
        dev_tx_ready = 1'b0;
        check("tx_popped", {31'd0, dev_tx_valid}, 32'd0);

        // RX path with wait states
        push_rx(8'h3C);
        do_read(20'h00300, 1'b0, h, d, w);
        check("rx_hit", {31'd0, h}, 32'd1);
        check("rx_data", {24'd0, d}, 32'h3C);
        check("rx_waits", w, 2);
        read_expect("rx_status", 20'h00301, 8'h02);

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            dev_rx_data = 8'(8'h10 + i); dev_rx_valid = 1'b1;
            @(negedge clock);
        end
        dev_rx_valid = 1'b0;
        check("ovf_rx_ready", {31'd0, dev_rx_ready}, 32'd0);
        read_expect("ovf_status", 20'h00301, 8'h07);
        do_write(20'h00301, 8'h04);
        read_expect("ovf_cleared", 20'h00301, 8'h03);
        for (int i = 0; i < 16; i++) begin
            do_read(20'h00300, 1'b0, h, d, w);
            check($sformatf("order%0d", i), {24'd0, d}, 32'(8'h10 + i));
            check($sformatf("order%0d_waits", i), w, 2);
        end
        read_expect("drained_status", 20'h00301, 8'h02);

        // DMA read
        push_rx(8'h77);
        do_write(20'h00302, 8'h02);
        check("drq_set", {31'd0, dma_request}, 32'd1);
        dma_acknowledge_n = 1'b0;
        @(negedge clock);
        ra = 20'($urandom);
        do_read(ra, 1'b1, h, d, w);
        check("dma_hit", {31'd0, h}, 32'd1);
        check("dma_data", {24'd0, d}, 32'h77);
        check("drq_dropped", {31'd0, dma_request}, 32'd0);
        dma_acknowledge_n = 1'b1;
        repeat (3) @(negedge clock);
        check("drq_stays_low", {31'd0, dma_request}, 32'd0);
        do_write(20'h00302, 8'h00);

        // Terminal count during a DMA read
        push_rx(8'h42);
        do_write(20'h00302, 8'h03);
        dma_acknowledge_n = 1'b0; terminal_count_n = 1'b0;
        @(negedge clock);
        ra = 20'($urandom);
        do_read(ra, 1'b1, h, d, w);
        check("tc_data", {24'd0, d}, 32'h42);
        terminal_count_n = 1'b1; dma_acknowledge_n = 1'b1;
        repeat (2) @(negedge clock);
        do_read(20'h00301, 1'b0, h, d, w);
`ifdef ISA_TARGET_TC_IRQ_EN
        check("tc_flag", {31'd0, d[4]}, 32'd1);
        check("tc_irq", {31'd0, interrupt_request}, 32'd1);
        read_expect("tc_control", 20'h00302, 8'h01);
`else
        check("tc_flag", {31'd0, d[4]}, 32'd0);
        check("tc_irq", {31'd0, interrupt_request}, 32'd0);
        read_expect("tc_control", 20'h00302, 8'h03);
`endif
        do_write(20'h00301, 8'h10);
        do_write(20'h00302, 8'h00);

        // Flush empties both FIFOs and self-clears
        do_write(20'h00300, 8'h11);
        check("flush_pre_txv", {31'd0, dev_tx_valid}, 32'd1);
        push_rx(8'hAA);
        push_rx(8'hBB);
        do_write(20'h00302, 8'h04);
        check("flush_txv", {31'd0, dev_tx_valid}, 32'd0);
        read_expect("flush_status", 20'h00301, 8'h02);
        read_expect("flush_control", 20'h00302, 8'h00);

        // Reset during WAIT with the strobe held low
        push_rx(8'h99);
        address = 20'h00300; address_enable_n = 1'b0; io_read_n = 1'b0;
        @(negedge clock);
        check("pre_rst_wait", {31'd0, io_channel_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, io_channel_ready}, 32'd1);
        check("async_rst_en", {31'd0, data_bus_out_en}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("held_strobe_ready%0d", i), {31'd0, io_channel_ready}, 32'd1);
            check($sformatf("held_strobe_en%0d", i), {31'd0, data_bus_out_en}, 32'd0);
        end
        io_read_n = 1'b1;
        @(negedge clock);
        read_expect("post_rst_status", 20'h00301, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
